// File: rtl/lsu_arbiter.sv
// Two-requester arbiter in front of the load/store unit: round-robin with bounded lock,
// misalignment screening, and a registered one-cycle load response per requester.
module lsu_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic        i_m1_req,
  input  logic        i_m0_lock,
  input  logic        i_m1_lock,
  input  logic        i_m0_wren,
  input  logic        i_m1_wren,
  input  logic        i_m0_unsigned,
  input  logic        i_m1_unsigned,
  input  logic [1:0]  i_m0_size,
  input  logic [1:0]  i_m1_size,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m1_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m0_err,
  output logic        o_m1_err,
  output logic [15:0] o_lsu_addr,
  output logic        o_lsu_wren,
  output logic [31:0] o_lsu_st_data,
  output logic [1:0]  o_lsu_length,
  output logic        o_lsu_unsigned,
  input  logic [31:0] i_lsu_ld_data
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic [7:0] hold_q, hold_d;

  logic       xfer;
  logic       sel;
  logic       use_m1;
  logic       x_lock;
  logic       x_wren;
  logic       other_req;
  logic       aligned;
  logic       resp;

  // xfer doubles as "something is selected": the selected requester's gnt is its req
  always_comb begin
    xfer = 1'b0;
    sel  = 1'b0;
    unique case (state_q)
      IDLE: begin
        xfer = i_m0_req | i_m1_req;
        sel  = (i_m0_req & i_m1_req) ? rr_q : i_m1_req;
      end
      LOCK0: begin
        xfer = i_m0_req;
        sel  = 1'b0;
      end
      LOCK1: begin
        xfer = i_m1_req;
        sel  = 1'b1;
      end
      default: begin
        xfer = 1'b0;
        sel  = 1'b0;
      end
    endcase
  end

  assign o_m0_gnt = xfer & ~sel;
  assign o_m1_gnt = xfer & sel;
  assign use_m1   = xfer & sel;

  assign o_lsu_addr     = use_m1 ? i_m1_addr     : i_m0_addr;
  assign o_lsu_st_data  = use_m1 ? i_m1_wdata    : i_m0_wdata;
  assign o_lsu_length   = use_m1 ? i_m1_size     : i_m0_size;
  assign o_lsu_unsigned = use_m1 ? i_m1_unsigned : i_m0_unsigned;
  assign x_lock         = use_m1 ? i_m1_lock     : i_m0_lock;
  assign x_wren         = use_m1 ? i_m1_wren     : i_m0_wren;
  assign other_req      = sel ? i_m0_req : i_m1_req;

  always_comb begin
    aligned = 1'b0;
    unique case (o_lsu_length)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~o_lsu_addr[0];
      2'b10:   aligned = (o_lsu_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign o_lsu_wren = xfer & x_wren & aligned;
  // loads and every misaligned access produce a response; aligned stores do not
  assign resp       = xfer & (~aligned | ~x_wren);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    if (xfer) rr_d = ~sel;
    unique case (state_q)
      IDLE: begin
        if (xfer && x_lock) begin
          state_d = sel ? LOCK1 : LOCK0;
          hold_d  = 8'd1;
        end
      end
      LOCK0, LOCK1: begin
        if (!xfer || !x_lock) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else if (other_req) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      hold_q      <= '0;
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
      o_m0_rdata  <= '0;
      o_m1_rdata  <= '0;
      o_m0_err    <= 1'b0;
      o_m1_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      o_m0_rvalid <= resp & ~sel;
      o_m1_rvalid <= resp & sel;
      o_m0_rdata  <= (resp & ~sel & aligned) ? i_lsu_ld_data : '0;
      o_m1_rdata  <= (resp & sel & aligned) ? i_lsu_ld_data : '0;
      o_m0_err    <= resp & ~sel & ~aligned;
      o_m1_err    <= resp & sel & ~aligned;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_lsu_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req[2], lock[2], wren[2], uns[2];
  logic [1:0]  size[2];
  logic [15:0] addr[2];
  logic [31:0] wdata[2];
  logic [31:0] ld_data;

  logic        gnt0, gnt1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;
  logic [15:0] lsu_addr;
  logic        lsu_wren, lsu_uns;
  logic [31:0] lsu_st;
  logic [1:0]  lsu_len;

  int pass_cnt = 0;
  int total_cnt = 0;

  // model: who holds the lock (-1 none), how many locked transfers so far, preferred requester
  int owner = -1;
  int run_len = 0;
  int pref = 0;

  logic        e_gnt[2], e_rv[2], e_er[2];
  logic [31:0] e_rd[2];
  logic [15:0] e_addr;
  logic        e_wren, e_uns;
  logic [31:0] e_st;
  logic [1:0]  e_len;

  logic        ob_gnt[2], ob_rv[2], ob_er[2];
  logic [31:0] ob_rd[2];
  logic [15:0] ob_addr;
  logic        ob_wren, ob_uns;
  logic [31:0] ob_st;
  logic [1:0]  ob_len;

  lsu_arbiter #(.HOLD_MAX(HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(req[0]), .i_m1_req(req[1]),
    .i_m0_lock(lock[0]), .i_m1_lock(lock[1]),
    .i_m0_wren(wren[0]), .i_m1_wren(wren[1]),
    .i_m0_unsigned(uns[0]), .i_m1_unsigned(uns[1]),
    .i_m0_size(size[0]), .i_m1_size(size[1]),
    .i_m0_addr(addr[0]), .i_m1_addr(addr[1]),
    .i_m0_wdata(wdata[0]), .i_m1_wdata(wdata[1]),
    .o_m0_gnt(gnt0), .o_m1_gnt(gnt1),
    .o_m0_rvalid(rv0), .o_m1_rvalid(rv1),
    .o_m0_rdata(rd0), .o_m1_rdata(rd1),
    .o_m0_err(er0), .o_m1_err(er1),
    .o_lsu_addr(lsu_addr), .o_lsu_wren(lsu_wren), .o_lsu_st_data(lsu_st),
    .o_lsu_length(lsu_len), .o_lsu_unsigned(lsu_uns),
    .i_lsu_ld_data(ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  function automatic bit is_aligned(logic [1:0] s, logic [15:0] a);
    int unsigned ai = int'(a);
    return (s == 2'd0) || (s == 2'd1 && ai % 2 == 0) || (s == 2'd2 && ai % 4 == 0);
  endfunction

  task automatic set_req(int i, logic r, logic l, logic w, logic [1:0] s, logic [15:0] a);
    req[i] = r; lock[i] = l; wren[i] = w; uns[i] = 1'b0; size[i] = s; addr[i] = a;
    wdata[i] = $urandom;
  endtask

  task automatic rand_req(int i);
    req[i]   = ($urandom % 4) != 0;
    lock[i]  = ($urandom % 3) == 0;
    wren[i]  = $urandom % 2;
    uns[i]   = $urandom % 2;
    size[i]  = 2'($urandom % 4);
    addr[i]  = 16'h2000 + 16'($urandom % 8);
    wdata[i] = $urandom;
  endtask

  // One clock: predict, sample combinational outputs at negedge, sample response after posedge, advance model.
  task automatic cycle();
    int win;
    int k;
    bit al;
    @(negedge clk);
    if (owner < 0) win = (req[0] && req[1]) ? pref : (req[0] ? 0 : (req[1] ? 1 : -1));
    else           win = req[owner] ? owner : -1;
    k  = (win == 1) ? 1 : 0;
    al = is_aligned(size[k], addr[k]);
    for (int i = 0; i < 2; i++) begin
      e_gnt[i] = (win == i); e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = '0;
    end
    e_addr = addr[k]; e_st = wdata[k]; e_len = size[k]; e_uns = uns[k];
    e_wren = (win >= 0) && wren[k] && al;
    if (win >= 0 && (!al || !wren[k])) begin
      e_rv[k] = 1'b1; e_er[k] = !al; e_rd[k] = al ? ld_data : 32'd0;
    end
    ob_gnt[0] = gnt0; ob_gnt[1] = gnt1;
    ob_addr = lsu_addr; ob_wren = lsu_wren; ob_st = lsu_st; ob_len = lsu_len; ob_uns = lsu_uns;
    @(posedge clk);
    #1;
    ob_rv[0] = rv0; ob_rv[1] = rv1; ob_er[0] = er0; ob_er[1] = er1; ob_rd[0] = rd0; ob_rd[1] = rd1;
    if (win < 0) begin
      owner = -1; run_len = 0;
    end else begin
      pref = 1 - win;
      if (owner < 0) begin
        if (lock[win]) begin owner = win; run_len = 1; end
      end else if (!lock[win]) begin
        owner = -1; run_len = 0;
      end else if (run_len < HOLD - 1) begin
        run_len++;
      end else if (req[1 - win]) begin
        owner = -1; run_len = 0;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 1'b0, 2'd0, 16'h2000);
    ld_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    owner = -1; run_len = 0; pref = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 1'b0, 2'd0, 16'h2000);
    rst_n = 1'b0;
    #7;
    total_cnt++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1); else pass_cnt++;
    total_cnt++; if (rv0 !== 1'b0 || rv1 !== 1'b0) $display("FAIL reset_rvalid: got %b%b want 00", rv0, rv1); else pass_cnt++;
    total_cnt++; if (rd0 !== 32'd0 || rd1 !== 32'd0) $display("FAIL reset_rdata: got %h %h want 0 0", rd0, rd1); else pass_cnt++;
    total_cnt++; if (er0 !== 1'b0 || er1 !== 1'b0 || lsu_wren !== 1'b0) $display("FAIL reset_err_wren: got %b%b%b want 000", er0, er1, lsu_wren); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 2'd2, 16'h2004);
    ld_data = 32'hDEADBEEF;
    cycle();
    total_cnt++; if (ob_gnt[0] !== 1'b1 || ob_gnt[1] !== 1'b0) $display("FAIL single_gnt: got %b%b want 10", ob_gnt[0], ob_gnt[1]); else pass_cnt++;
    total_cnt++; if (ob_addr !== 16'h2004) $display("FAIL single_addr: got %h want 2004", ob_addr); else pass_cnt++;
    total_cnt++; if (ob_rv[0] !== 1'b1 || ob_er[0] !== 1'b0) $display("FAIL single_rv_err: got %b%b want 10", ob_rv[0], ob_er[0]); else pass_cnt++;
    total_cnt++; if (ob_rd[0] !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h want deadbeef", ob_rd[0]); else pass_cnt++;
    total_cnt++; if (ob_rv[1] !== 1'b0 || ob_er[1] !== 1'b0 || ob_rd[1] !== 32'd0) $display("FAIL single_m1_quiet: got %b %b %h want 0 0 0", ob_rv[1], ob_er[1], ob_rd[1]); else pass_cnt++;
    req[0] = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [15:0] want_addr;
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 2'd2, 16'h2010);
    set_req(1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h2020);
    for (int c = 0; c < 4; c++) begin
      ld_data = $urandom;
      cycle();
      want_addr = (c % 2 == 0) ? 16'h2010 : 16'h2020;
      total_cnt++; if (ob_gnt[0] !== (c % 2 == 0) || ob_gnt[1] !== (c % 2 == 1)) $display("FAIL rr_gnt c%0d: got %b%b want %b%b", c, ob_gnt[0], ob_gnt[1], c % 2 == 0, c % 2 == 1); else pass_cnt++;
      total_cnt++; if (ob_addr !== want_addr) $display("FAIL rr_addr c%0d: got %h want %h", c, ob_addr, want_addr); else pass_cnt++;
      total_cnt++; if (ob_rv[c % 2] !== 1'b1 || ob_rv[1 - c % 2] !== 1'b0) $display("FAIL rr_rvalid c%0d: got %b%b", c, ob_rv[0], ob_rv[1]); else pass_cnt++;
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h2001);
    cycle();
    set_req(1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h2003);
    for (int c = 1; c <= 5; c++) begin
      cycle();
      total_cnt++; if (ob_gnt[1] !== (c <= HOLD) || ob_gnt[0] !== (c > HOLD)) $display("FAIL lock_gnt c%0d: got m0=%b m1=%b want m0=%b m1=%b", c, ob_gnt[0], ob_gnt[1], c > HOLD, c <= HOLD); else pass_cnt++;
    end
  endtask

  task automatic test_lock_saturate();
    do_reset();
    set_req(1, 1'b1, 1'b1, 1'b1, 2'd2, 16'h2008);
    for (int c = 0; c < 6; c++) begin
      cycle();
      total_cnt++; if (ob_gnt[1] !== 1'b1) $display("FAIL sat_hold c%0d: got %b want 1", c, ob_gnt[1]); else pass_cnt++;
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h2006);
    cycle();
    total_cnt++; if (ob_gnt[1] !== 1'b1 || ob_gnt[0] !== 1'b0) $display("FAIL sat_last: got m0=%b m1=%b want m0=0 m1=1", ob_gnt[0], ob_gnt[1]); else pass_cnt++;
    cycle();
    total_cnt++; if (ob_gnt[0] !== 1'b1 || ob_gnt[1] !== 1'b0) $display("FAIL sat_release: got m0=%b m1=%b want m0=1 m1=0", ob_gnt[0], ob_gnt[1]); else pass_cnt++;
  endtask

  task automatic test_voluntary();
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h2000);
    cycle();
    set_req(1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h200C);
    cycle();
    total_cnt++; if (ob_gnt[0] !== 1'b1 || ob_gnt[1] !== 1'b0) $display("FAIL vol_locked: got m0=%b m1=%b want m0=1 m1=0", ob_gnt[0], ob_gnt[1]); else pass_cnt++;
    req[0] = 1'b0;
    cycle();
    total_cnt++; if (ob_gnt[1] !== 1'b0) $display("FAIL vol_drop: got m1=%b want 0", ob_gnt[1]); else pass_cnt++;
    cycle();
    total_cnt++; if (ob_gnt[1] !== 1'b1) $display("FAIL vol_idle_m1: got m1=%b want 1", ob_gnt[1]); else pass_cnt++;
  endtask

  task automatic test_misalign();
    do_reset();
    set_req(1, 1'b1, 1'b0, 1'b1, 2'd2, 16'h2002);
    ld_data = 32'hA5A5_5A5A;
    cycle();
    total_cnt++; if (ob_gnt[1] !== 1'b1 || ob_wren !== 1'b0) $display("FAIL mis_word_gnt_wren: got %b %b want 1 0", ob_gnt[1], ob_wren); else pass_cnt++;
    total_cnt++; if (ob_rv[1] !== 1'b1 || ob_er[1] !== 1'b1 || ob_rd[1] !== 32'd0) $display("FAIL mis_word_resp: got %b %b %h want 1 1 0", ob_rv[1], ob_er[1], ob_rd[1]); else pass_cnt++;
    set_req(1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h2002);
    cycle();
    total_cnt++; if (ob_wren !== 1'b1 || ob_len !== 2'd1) $display("FAIL mis_half_wren: got %b len %0d want 1 len 1", ob_wren, ob_len); else pass_cnt++;
    total_cnt++; if (ob_rv[1] !== 1'b0 || ob_rv[0] !== 1'b0) $display("FAIL mis_half_noresp: got %b%b want 00", ob_rv[0], ob_rv[1]); else pass_cnt++;
    req[1] = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h2008);
    ld_data = 32'h1234_5678;
    cycle();
    total_cnt++; if (ob_rv[0] !== 1'b1 || ob_rd[0] !== 32'h1234_5678) $display("FAIL mid_pre: got %b %h want 1 12345678", ob_rv[0], ob_rd[0]); else pass_cnt++;
    req[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if (rv0 !== 1'b0) $display("FAIL mid_rvalid_drop: got %b want 0", rv0); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    owner = -1; run_len = 0; pref = 0;
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h2001);
    set_req(1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h2005);
    cycle();
    total_cnt++; if (ob_gnt[0] !== 1'b1 || ob_gnt[1] !== 1'b0) $display("FAIL mid_first: got m0=%b m1=%b want m0=1 m1=0", ob_gnt[0], ob_gnt[1]); else pass_cnt++;
    cycle();
    total_cnt++; if (ob_gnt[1] !== 1'b1 || ob_gnt[0] !== 1'b0) $display("FAIL mid_second: got m0=%b m1=%b want m0=0 m1=1", ob_gnt[0], ob_gnt[1]); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    rand_req(0);
    rand_req(1);
    for (int c = 0; c < 400; c++) begin
      ld_data = $urandom;
      cycle();
      total_cnt++; if (ob_gnt[0] !== e_gnt[0] || ob_gnt[1] !== e_gnt[1]) $display("FAIL rnd_gnt c%0d: got %b%b want %b%b", c, ob_gnt[0], ob_gnt[1], e_gnt[0], e_gnt[1]); else pass_cnt++;
      total_cnt++; if (ob_addr !== e_addr || ob_st !== e_st || ob_len !== e_len || ob_uns !== e_uns) $display("FAIL rnd_lsu c%0d: got %h %h %0d %b want %h %h %0d %b", c, ob_addr, ob_st, ob_len, ob_uns, e_addr, e_st, e_len, e_uns); else pass_cnt++;
      total_cnt++; if (ob_wren !== e_wren) $display("FAIL rnd_wren c%0d: got %b want %b", c, ob_wren, e_wren); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
        total_cnt++; if (ob_rv[i] !== e_rv[i]) $display("FAIL rnd_rvalid%0d c%0d: got %b want %b", i, c, ob_rv[i], e_rv[i]); else pass_cnt++;
        if (e_rv[i]) begin
          total_cnt++; if (ob_rd[i] !== e_rd[i] || ob_er[i] !== e_er[i]) $display("FAIL rnd_resp%0d c%0d: got %h %b want %h %b", i, c, ob_rd[i], ob_er[i], e_rd[i], e_er[i]); else pass_cnt++;
        end
      end
      for (int i = 0; i < 2; i++) if (!req[i] || e_gnt[i]) rand_req(i);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_release();
    test_lock_saturate();
    test_voluntary();
    test_misalign();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

- Shares the single load/store unit port between two requesters: m0 (core pipeline) and m1 (debug/boot loader).
- Arbitration is round-robin, with an optional bounded lock so a requester can run back-to-back transfers.
- Each transfer is checked for misalignment before it reaches the LSU. Load data comes back on a registered response channel.
- The block sits between the requesters and the LSU; its LSU-side outputs drive the LSU address/store/length inputs directly.

## Interface
- HOLD_MAX, default 8: maximum number of consecutive locked transfers while the other requester waits (legal range 2–255).
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_m0_req, i_m1_req  in  1  request valid; must stay stable with its attributes until granted.
- i_m0_lock, i_m1_lock  in  1  request to keep ownership after this transfer.
- i_m0_wren, i_m1_wren  in  1  1 = store, 0 = load.
- i_m0_unsigned, i_m1_unsigned  in  1  load is zero-extended.
- i_m0_size, i_m1_size  in  2  transfer size: 00 byte, 01 half, 10 word; 11 is illegal.
- i_m0_addr, i_m1_addr  in  16  byte address.
- i_m0_wdata, i_m1_wdata  in  32  store data.
- o_m0_gnt, o_m1_gnt  out  1  combinational grant; a transfer occurs in any cycle with req & gnt.
- o_m0_rvalid, o_m1_rvalid  out  1  load response valid, one cycle.
- o_m0_rdata, o_m1_rdata  out  32  load response data.
- o_m0_err, o_m1_err  out  1  response is an error; qualified by rvalid.
- o_lsu_addr  out  16  address to the LSU.
- o_lsu_wren  out  1  write enable to the LSU.
- o_lsu_st_data  out  32  store data to the LSU.
- o_lsu_length  out  2  transfer size to the LSU.
- o_lsu_unsigned  out  1  unsigned-load flag to the LSU.
- i_lsu_ld_data  in  32  combinational load data from the LSU.

## Operation
- **State machine.** States are IDLE, LOCK0 and LOCK1. A 1-bit round-robin pointer rr names the preferred requester. hold_cnt is an 8-bit counter.
- **Selection in IDLE.** If only one requester is asserting req, it is selected. If both are, requester rr is selected.
- **Selection in LOCKx.** Only mx can be selected; the other requester's gnt is 0.
- **Grant.** The selected requester's gnt equals its req. At most one gnt is high per cycle.
- **LSU-side muxing.** The LSU outputs carry the selected requester's attributes; they show m0's attributes when nothing is selected.
- **LSU write enable.** o_lsu_wren = transfer & wren & aligned.
- **Alignment rule.** Word requires addr[1:0] = 0. Half requires addr[0] = 0. Byte is always aligned. Size 11 is always misaligned.
- **Misaligned transfer.** The transfer is still granted and consumed. o_lsu_wren is forced to 0. A response with err = 1 and rdata = 0 is returned for both loads and stores.
- **Aligned load.** rdata is captured from i_lsu_ld_data at the transfer edge. rvalid = 1 and err = 0 in the next cycle.
- **Aligned store.** No response is returned.
- **On any transfer by mx:** rr is set to the other requester (!x).
- **IDLE → LOCKx** when mx transfers with lock = 1. hold_cnt is set to 1.
- **LOCKx → LOCKx** when mx transfers with lock = 1 and hold_cnt < HOLD_MAX-1. hold_cnt increments.
- **LOCKx → IDLE** on any of the following:
  - mx transfers with lock = 0;
  - a cycle in which mx's req = 0;
  - mx transfers while hold_cnt = HOLD_MAX-1 and the other requester's req = 1 (forced release).
- **Forced release.** After a forced release, rr points to the waiting requester, so it wins the next cycle.
- **Lock with no contender.** If the other requester is idle at hold_cnt = HOLD_MAX-1, the state stays LOCKx and hold_cnt saturates.
- **hold_cnt** clears on every entry to IDLE.

## Timing
- Grant is combinational in the request cycle: zero-cycle arbitration, no bubble on an owner change.
- Load latency is exactly 1 cycle from the transfer edge to rvalid. Throughput is 1 transfer per cycle.
- Back-to-back loads give back-to-back rvalid pulses, each tagged to its own requester.
- LSU stores commit at the transfer edge.
- **Reset values:**
  - state = IDLE, rr = 0, hold_cnt = 0;
  - all rvalid and err = 0, all rdata = 0;
  - gnt and o_lsu_wren = 0 whenever no req is asserted.
- **Reset asserted mid-operation:** a pending response is dropped (rvalid is not produced) and the lock is cleared immediately.
- Requests are not observed while i_rst_n = 0.

## Test plan
- **Single requester.** After reset, m0 loads word 0x2004 with the LSU returning 0xDEADBEEF. Required: o_m0_gnt same cycle; next cycle o_m0_rvalid = 1, o_m0_rdata = 0xDEADBEEF, o_m0_err = 0; m1 outputs stay 0.
- **Round-robin.** Both requesters request continuously, no lock. Required: grants go m0, m1, m0, m1 for 4 cycles; o_lsu_addr alternates accordingly.
- **Lock and forced release.** HOLD_MAX = 4. m1 requests with lock = 1 while m0 requests throughout. Required: m1 is granted 4 consecutive cycles, then m0 is granted; m0's gnt is 0 during LOCK1.
- **Voluntary release.** m0 is locked at hold_cnt = 2 and then drops req for one cycle. Required: IDLE next cycle; m1 is granted if requesting.
- **Misalignment.** m1 stores a word to 0x2002. Required: gnt = 1 and o_lsu_wren = 0; next cycle o_m1_rvalid = 1, o_m1_err = 1, o_m1_rdata = 0. A half store to 0x2002 instead drives o_lsu_wren = 1 with no response.
- **Reset mid-flight.** Assert i_rst_n = 0 asynchronously in the cycle after an aligned load transfer. Required: o_m0_rvalid = 0 immediately; after release, state is IDLE and m0 wins the first contention.
